// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: difference and borrow of a - b - borrow_in.
module full_subtractor
    import serial_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic difference,
    output logic borrow_out
);

    // Purely combinational subtract cell
    always_comb begin
        difference = a ^ b ^ borrow_in;
        borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b computed LSB first, one bit per clock.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit processed per cycle, WIDTH cycles
// DONE  | single cycle, results valid, start may begin the next operation
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bo_q, bo_d;
    logic             ov_q, ov_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fs_d;
    logic             fs_bo;
    logic [WIDTH-1:0] res_shift;

    full_subtractor u_fs (
        .a          (a_sh_q[0]),
        .b          (b_sh_q[0]),
        .borrow_in  (br_q),
        .difference (fs_d),
        .borrow_out (fs_bo)
    );

    // Next-state, datapath shifting and result capture
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        br_d      = br_q;
        cnt_d     = cnt_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        diff_d    = diff_q;
        bo_d      = bo_q;
        ov_d      = ov_q;
        // new bit enters at the MSB end so after WIDTH shifts bit 0 is the LSB
        res_shift              = res_q >> 1;
        res_shift[WIDTH-1]     = fs_d;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = CW'(WIDTH - 1);
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d  = res_shift;
                br_d   = fs_bo;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    diff_d  = res_shift;
                    bo_d    = fs_bo;
                    // last processed bit is the sign bit of the result
                    ov_d    = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign difference = diff_q;
    assign borrow_out = bo_q;
    assign overflow   = ov_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor. It computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a borrow register. It is the area-minimal counterpart to the common adder cells in `src/common/`. Datapath blocks that can tolerate WIDTH-cycle latency use it, and it reports a `done` pulse when the result is ready.

## Interface

Parameters:
- `WIDTH`, default 32: operand and result width in bits; legal range is `WIDTH >= 1`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a subtraction; sampled only in IDLE or DONE.
- `a`  in  WIDTH  minuend; captured on an accepted `start`.
- `b`  in  WIDTH  subtrahend; captured on an accepted `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result outputs are valid.
- `difference`  out  WIDTH  `(a - b) mod 2^WIDTH`.
- `borrow_out`  out  1  unsigned borrow (1 iff `a < b` unsigned).
- `overflow`  out  1  signed overflow of `a - b` in two's complement.

One clock domain. Reset is synchronous and active-high. The ports are named `clk` and `rst`.

## Operation

- State machine with three states:
  - IDLE: waiting.
  - RUN: one bit processed per cycle.
  - DONE: exactly one cycle; `done` = 1.
- IDLE or DONE with `start` = 1:
  - capture `a` and `b` into shift registers;
  - borrow register <= 0; bit counter <= WIDTH-1;
  - next state RUN.
- IDLE or DONE with `start` = 0: IDLE -> IDLE; DONE -> IDLE.
- RUN, per cycle, with i = the current LSB of the operand shift registers:
  - d = a_i ^ b_i ^ br;
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  - shift d into the result register at the MSB end (shift right);
  - shift both operand registers right by 1;
  - decrement the counter.
- RUN with counter == 0: the final bit is processed this cycle and the next state is DONE.
- Result updates, made on the RUN -> DONE edge:
  - `difference` <= full result register;
  - `borrow_out` <= br';
  - `overflow` <= (a_msb != b_msb) && (d_msb != a_msb), where a_msb/b_msb are held from capture.
- Result outputs hold their value until the next RUN -> DONE edge or reset. They do not change during a new RUN.
- `start` in RUN is ignored: no restart and no queueing.
- `a` and `b` are don't-care except on the accepting cycle.

## Timing

- Reset (`rst` = 1 at an edge), applied in any state:
  - state <= IDLE;
  - `busy`, `done`, `difference`, `borrow_out`, `overflow` <= 0;
  - internal registers cleared.
- Reset has priority over `start`.
- Reset during RUN aborts the operation and produces no `done` pulse.
- Latency: `start` accepted at edge 0; `busy` is high for cycles 1..WIDTH; `done` is high in cycle WIDTH+1 (exactly WIDTH+1 edges after acceptance).
- WIDTH = 1: RUN lasts one cycle; `done` follows at cycle 2.
- Back-to-back operation: `start` during the DONE cycle is accepted, so RUN begins next cycle and `done` is never asserted on two consecutive cycles. Sustained throughput is one result per WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Shared include (`src/common/`): state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Counter width is `$clog2(WIDTH)` with a minimum of 1 bit; it is computed locally, not shared.
- One sub-module: `full_subtractor` (inputs `a`, `b`, `borrow_in`; outputs `difference`, `borrow_out`; purely combinational). It is instantiated once per serial slice.
- Top level holds the FSM, counter, operand/result shift registers, and the borrow register. Target size is roughly 150 lines.

## Test plan

Run at WIDTH = 8 unless noted.

- Basic: `a` = 0x05, `b` = 0x03, `start` pulse -> `busy` high 8 cycles, then `done` at cycle 9 with `difference` = 0x02, `borrow_out` = 0, `overflow` = 0.
- Unsigned borrow: `a` = 0x03, `b` = 0x05 -> `difference` = 0xFE, `borrow_out` = 1, `overflow` = 0. Also `a` = 0x00, `b` = 0x00 -> 0x00, 0, 0.
- Signed overflow: `a` = 0x80, `b` = 0x01 -> 0x7F, `borrow_out` = 0, `overflow` = 1. Also `a` = 0x7F, `b` = 0xFF -> 0x80, `borrow_out` = 1, `overflow` = 1.
- Protocol:
  - `start` with new operands 3 cycles into RUN is ignored; the original result appears at cycle 9.
  - `start` asserted in the DONE cycle -> second `done` exactly 9 cycles later; result registers hold the first result until then.
- Reset: `rst` at cycle 4 of RUN -> IDLE next cycle, all outputs 0, no `done`. A fresh `start` afterwards completes normally.
- Parameter sweep:
  - WIDTH = 1: 0 - 1 -> `difference` = 1, `borrow_out` = 1, `overflow` = 1, `done` at cycle 2.
  - WIDTH = 32: random vectors vs the reference model `a - b` -> exact match, `done` at cycle 33.
